serial_subtractor: RTL
======================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial unsigned subtractor, the counterpart to the half_adder arithmetic
//   cells: computes d = a - b and a borrow flag, one bit per clock, LSB first.
//   A single registered half/full-subtractor cell plus a borrow flip-flop is
//   reused WIDTH times.
//   Operands enter and results leave over valid/ready handshakes. It sits between
//   operand producers and consumers that tolerate multi-cycle latency in exchange
//   for minimal logic.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range WIDTH >= 1
//
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands a/b valid
//   in_ready   out  1      block accepts operands (IDLE and not in reset)
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   out_valid  out  1      d/bout valid
//   out_ready  in   1      consumer accepts result
//   d          out  WIDTH  difference, (a - b) mod 2^WIDTH
//   bout       out  1      final borrow, 1 iff a < b (unsigned)
//
// BEHAVIOUR
//   - Reset (async, rst=1): state=IDLE, out_valid=0, d=0, bout=0, borrow reg=0,
//     bit counter=0, shift regs=0; in_ready=0 while rst=1.
//   - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE) && !rst (combinational).
//   - IDLE: on edge with in_valid && in_ready: latch a, b into shift regs,
//     borrow=0, count=0, go RUN. in_valid while not ready is ignored (no queueing).
//   - RUN, per edge: a0/b0 = current LSBs; dbit = a0 ^ b0 ^ br;
//     br_next = (~a0 & b0) | (~(a0 ^ b0) & br); dbit shifts into result from MSB;
//     operand regs shift right; count++. On the edge where count==WIDTH-1:
//     go DONE, d = final result, bout = br_next, out_valid=1.
//   - Latency: out_valid rises exactly WIDTH edges after the accept edge.
//     WIDTH=1: one RUN cycle, behaves as a registered half subtractor.
//   - DONE: out_valid=1; d, bout held stable until out_ready=1. On edge with
//     out_valid && out_ready: go IDLE, out_valid=0 next cycle; d/bout retain last
//     value. Throughput: one op per WIDTH+2 cycles minimum.
//   - out_ready while out_valid=0 has no effect. No overlap of input and output phases.
//   - Reset mid-RUN or mid-DONE: operation abandoned, all outputs return to reset
//     values immediately (asynchronously); no result emitted after release.
//   - Counter width $clog2(WIDTH+1); no wrap beyond WIDTH-1 in RUN.
//
// TESTING
//   1. WIDTH=8, a=0x05 b=0x03 -> out_valid 8 edges after accept, d=0x02 bout=0.
//   2. WIDTH=8, a=0x03 b=0x05 -> d=0xFE bout=1; a=0x00 b=0xFF -> d=0x01 bout=1;
//      a=0xFF b=0xFF -> d=0x00 bout=0.
//   3. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b ->
//      d, bout, out_valid stable, in_ready=0; then out_ready=1 -> out_valid=0 and
//      in_ready=1 next cycle; back-to-back op accepted immediately.
//   4. Assert rst mid-RUN (after 3 bits) -> out_valid=0, d=0, bout=0 without a
//      clock edge; after release in_ready=1, new op a=0x10 b=0x01 -> d=0x0F bout=0.
//   5. WIDTH=1 truth table: (a,b)=00->d0 b0; 01->d1 b1; 10->d1 b0; 11->d0 b0,
//      each with out_valid one edge after accept.
//   6. WIDTH=4 exhaustive 256 pairs with random out_ready stalls and random
//      in_valid gaps -> every result matches (a-b)&0xF and a<b; no lost or
//      duplicated results; $error on mismatch.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b (mod 2^WIDTH) and borrow flag, one bit per clock,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             dbit;
    logic             br_next;
    logic [WIDTH:0]   res_shift;

    // Full-subtractor cell on the current LSBs
    assign dbit      = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Extra bit keeps the MSB-insert shift legal when WIDTH == 1
    assign res_shift = {dbit, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift[WIDTH:1];
                br_d  = br_next;
                if (cnt_q == LAST) begin
                    d_d     = res_shift[WIDTH:1];
                    bout_d  = br_next;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign d         = d_q;
    assign bout      = bout_q;

endmodule
